frog_hop_ctrl: RTL and testbench
================================

// Module: frog_hop_ctrl
// PURPOSE
//  Sequences the frog motion datapath: turns raw direction keys into discrete hops.
//  Each accepted press drives one move-request line for exactly HOP_TICKS timer_done
//  pulses, followed by a cooldown. Also owns the life/round state: on hit it pulses
//  reset_position, decrements lives and freezes input; at zero lives it waits for game_start.
// PARAMETERS
//  HOP_TICKS        8   timer_done pulses per hop (1..255)
//  COOLDOWN_TICKS   4   timer_done pulses ignored after a hop (0..255; 0 = no cooldown)
//  DEATH_HOLD_TICKS 30  timer_done pulses frozen after a hit (1..255)
//  LIVES            3   lives loaded at reset/game_start (1..7)
// PORTS
//  CLK            in   1  system clock
//  RESETn         in   1  asynchronous, active-low reset
//  timer_done     in   1  1-cycle movement tick, shared with the motion datapath
//  key_up/key_down/key_left/key_right  in 1 each  synchronised key levels, active-high
//  hit            in   1  collision/drown indication (level or pulse)
//  game_start     in   1  1-cycle restart request
//  up/down/left/right  out 1 each  move requests to motion datapath (at most one high)
//  reset_position out  1  1-cycle pulse: frog back to start
//  lives          out  3  remaining lives
//  game_over      out  1  high while in OVER
//  busy           out  1  high when state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, lives=LIVES, all move outputs/reset_position/game_over/busy=0,
//   counter=0, key_prev=4'b1111 (a key held through reset is NOT a press).
//  All outputs registered. States IDLE, HOP, COOL, DEAD, OVER.
//  Press detect: new = key & ~key_prev, key_prev updated every cycle in every state.
//   Held key never repeats; must be released and pressed again.
//  IDLE: any new press -> HOP, cnt<=HOP_TICKS, latch one direction.
//   Simultaneous presses: priority up > down > left > right.
//  HOP: latched dir output high from cycle after accept. On timer_done: cnt<=cnt-1;
//   if cnt==1 -> dir output low next cycle, go COOL (cnt<=COOLDOWN_TICKS) or IDLE
//   if COOLDOWN_TICKS==0. Dir is thus high on exactly HOP_TICKS timer_done cycles.
//   If timer_done coincides with the accept cycle, it is not counted.
//  COOL: all move outputs low; decrement on timer_done; cnt==1 & timer_done -> IDLE.
//  Presses in HOP/COOL/DEAD/OVER are dropped, not queued.
//  hit in IDLE/HOP/COOL: next cycle all move outputs 0, reset_position=1 (one cycle),
//   lives<=lives-1; if old lives==1 -> OVER, game_over=1, else DEAD, cnt<=DEATH_HOLD_TICKS.
//   hit ignored in DEAD and OVER (held hit costs exactly one life).
//  DEAD: decrement on timer_done; cnt==1 & timer_done -> IDLE.
//  game_start (any state, priority over hit and presses): lives<=LIVES, game_over<=0,
//   reset_position pulse, move outputs 0, state<=IDLE.
//  lives never underflows; never exceeds LIVES.
//  RESETn asserted mid-hop: outputs drop asynchronously to reset values.
// TESTING
//  key_up rises in IDLE, 20 timer_done pulses spaced 5 cycles -> up high on exactly 8
//   ticks, then COOL 4 ticks, busy falls after tick 12.
//  key_left+key_right rise same cycle -> only left asserted; hold keys -> no second hop.
//  key_down pressed during HOP tick 3 -> ignored; after COOL, fresh press required.
//  hit during HOP tick 5 -> down low next cycle, reset_position 1-cycle pulse,
//   lives 3->2, DEAD 30 ticks, hit held throughout -> lives stays 2.
//  three hits -> lives 0, game_over=1, keys ignored; game_start -> lives 3, game_over 0,
//   reset_position pulse, IDLE.
//  key held while RESETn released -> no hop; RESETn pulsed mid-hop -> all outputs 0, lives 3.

Source files
------------

// File: rtl/frog_hop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frog_hop_ctrl
// Description : Turns direction key presses into timed hops and owns the
//               life/round state (hit, death hold, game over, restart).
// Revision    : 1.0
// ============================================================================
module frog_hop_ctrl #(
    parameter int HOP_TICKS        = 8,
    parameter int COOLDOWN_TICKS   = 4,
    parameter int DEATH_HOLD_TICKS = 30,
    parameter int LIVES            = 3
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       timer_done,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       hit,
    input  logic       game_start,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       reset_position,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       busy
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_hop  = 3'd1;
    localparam logic [2:0] c_cool = 3'd2;
    localparam logic [2:0] c_dead = 3'd3;
    localparam logic [2:0] c_over = 3'd4;

    localparam logic [7:0] c_hop_ticks   = 8'(HOP_TICKS);
    localparam logic [7:0] c_cool_ticks  = 8'(COOLDOWN_TICKS);
    localparam logic [7:0] c_death_ticks = 8'(DEATH_HOLD_TICKS);
    localparam logic [2:0] c_lives       = 3'(LIVES);

    // Move vectors are ordered {up, down, left, right}
    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_key_prev;
    logic [3:0] r_dir;
    logic [3:0] r_move;
    logic       r_reset_position;
    logic [2:0] r_lives;
    logic       r_game_over;
    logic       r_busy;

    logic [2:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] w_dir_nxt;
    logic [3:0] w_move_nxt;
    logic       w_reset_position_nxt;
    logic [2:0] w_lives_nxt;
    logic       w_game_over_nxt;
    logic       w_busy_nxt;

    logic [3:0] w_keys;
    logic [3:0] w_new;
    logic [3:0] w_pick;
    logic       w_hit_live;

    assign w_keys = {key_up, key_down, key_left, key_right};
    assign w_new  = w_keys & ~r_key_prev;

    // Fixed priority: up > down > left > right
    always_comb begin
        w_pick = 4'b0000;
        if (w_new[3])      w_pick = 4'b1000;
        else if (w_new[2]) w_pick = 4'b0100;
        else if (w_new[1]) w_pick = 4'b0010;
        else if (w_new[0]) w_pick = 4'b0001;
    end

    // A hit only counts while the frog is alive and controllable
    assign w_hit_live = hit && ((r_state == c_idle) || (r_state == c_hop) ||
                                (r_state == c_cool));

    // ------------------------------------------------------------------
    // State and output register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state          <= c_idle;
            r_cnt            <= 8'd0;
            r_key_prev       <= 4'b1111;
            r_dir            <= 4'b0000;
            r_move           <= 4'b0000;
            r_reset_position <= 1'b0;
            r_lives          <= c_lives;
            r_game_over      <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_key_prev       <= w_keys;
            r_dir            <= w_dir_nxt;
            r_move           <= w_move_nxt;
            r_reset_position <= w_reset_position_nxt;
            r_lives          <= w_lives_nxt;
            r_game_over      <= w_game_over_nxt;
            r_busy           <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        if (game_start) begin
            w_state_nxt = c_idle;
            w_cnt_nxt   = 8'd0;
            w_dir_nxt   = 4'b0000;
        end else if (w_hit_live) begin
            w_dir_nxt = 4'b0000;
            if (r_lives <= 3'd1) begin
                w_state_nxt = c_over;
                w_cnt_nxt   = 8'd0;
            end else begin
                w_state_nxt = c_dead;
                w_cnt_nxt   = c_death_ticks;
            end
        end else begin
            case (r_state)
                c_idle: begin
                    if (|w_new) begin
                        w_state_nxt = c_hop;
                        w_cnt_nxt   = c_hop_ticks;
                        w_dir_nxt   = w_pick;
                    end
                end
                c_hop: begin
                    if (timer_done) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            w_dir_nxt = 4'b0000;
                            if (c_cool_ticks == 8'd0) begin
                                w_state_nxt = c_idle;
                            end else begin
                                w_state_nxt = c_cool;
                                w_cnt_nxt   = c_cool_ticks;
                            end
                        end
                    end
                end
                c_cool, c_dead: begin
                    if (timer_done) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) w_state_nxt = c_idle;
                    end
                end
                c_over: begin
                    w_state_nxt = c_over;
                end
                default: begin
                    w_state_nxt = c_idle;
                    w_cnt_nxt   = 8'd0;
                    w_dir_nxt   = 4'b0000;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (values registered above)
    // ------------------------------------------------------------------
    always_comb begin
        w_move_nxt           = 4'b0000;
        w_reset_position_nxt = 1'b0;
        w_lives_nxt          = r_lives;
        w_game_over_nxt      = (w_state_nxt == c_over);
        w_busy_nxt           = (w_state_nxt != c_idle);
        if (w_state_nxt == c_hop) w_move_nxt = w_dir_nxt;
        if (game_start) begin
            w_reset_position_nxt = 1'b1;
            w_lives_nxt          = c_lives;
        end else if (w_hit_live) begin
            w_reset_position_nxt = 1'b1;
            if (r_lives != 3'd0) w_lives_nxt = r_lives - 3'd1;
        end
    end

    assign up             = r_move[3];
    assign down           = r_move[2];
    assign left           = r_move[1];
    assign right          = r_move[0];
    assign reset_position = r_reset_position;
    assign lives          = r_lives;
    assign game_over      = r_game_over;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_frog_hop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frog_hop_ctrl
// Description : Directed self-checking bench for frog_hop_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_frog_hop_ctrl;

    logic       clk;
    logic       rstn;
    logic       timer_done;
    logic       key_up, key_down, key_left, key_right;
    logic       hit, game_start;
    logic       up, down, left, right;
    logic       reset_position;
    logic [2:0] lives;
    logic       game_over, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_up, n_down, n_left, n_right;

    frog_hop_ctrl #(
        .HOP_TICKS(8), .COOLDOWN_TICKS(4), .DEATH_HOLD_TICKS(30), .LIVES(3)
    ) dut (
        .CLK(clk), .RESETn(rstn), .timer_done(timer_done),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .hit(hit), .game_start(game_start),
        .up(up), .down(down), .left(left), .right(right),
        .reset_position(reset_position), .lives(lives),
        .game_over(game_over), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        n_up = 0; n_down = 0; n_left = 0; n_right = 0;
    endtask

    // One timer_done pulse, then idle so pulses are 5 cycles apart
    task automatic tick();
        timer_done = 1'b1;
        if (up)    n_up++;
        if (down)  n_down++;
        if (left)  n_left++;
        if (right) n_right++;
        @(negedge clk);
        timer_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] mv();
        return {4'b0000, up, down, left, right};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: timed out at %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; timer_done = 1'b0; hit = 1'b0; game_start = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        step(3);
        check("rst_lives", 8'(lives), 8'd3);
        check("rst_moves", mv(), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_gover", 8'(game_over), 8'd0);
        check("rst_rpos", 8'(reset_position), 8'd0);
        rstn = 1'b1;
        step(3);

        // Basic hop with cooldown
        key_up = 1'b1;
        step(1);
        check("hop1_up", mv(), 8'b1000);
        check("hop1_busy", 8'(busy), 8'd1);
        clr_counts();
        ticks(7);
        check("hop1_up_t7", 8'(up), 8'd1);
        tick();
        check("hop1_up_t8", 8'(up), 8'd0);
        check("hop1_busy_t8", 8'(busy), 8'd1);
        ticks(3);
        check("hop1_busy_t11", 8'(busy), 8'd1);
        tick();
        check("hop1_busy_t12", 8'(busy), 8'd0);
        ticks(8);
        check("hop1_up_cnt", 8'(n_up), 8'd8);
        check("hop1_no_repeat", 8'(busy), 8'd0);
        key_up = 1'b0;
        step(2);

        // Simultaneous presses: left wins
        key_left = 1'b1; key_right = 1'b1;
        step(1);
        check("prio_lr", mv(), 8'b0010);
        clr_counts();
        ticks(12);
        step(5);
        check("prio_left_cnt", 8'(n_left), 8'd8);
        check("prio_right_cnt", 8'(n_right), 8'd0);
        check("prio_held_idle", 8'(busy), 8'd0);
        key_left = 1'b0; key_right = 1'b0;
        step(2);

        // Press during hop is dropped, needs fresh press afterwards
        key_up = 1'b1;
        step(1);
        clr_counts();
        ticks(3);
        key_down = 1'b1;
        ticks(9);
        step(3);
        check("drop_busy", 8'(busy), 8'd0);
        check("drop_down", 8'(down), 8'd0);
        check("drop_up_cnt", 8'(n_up), 8'd8);
        check("drop_down_cnt", 8'(n_down), 8'd0);
        key_up = 1'b0; key_down = 1'b0;
        step(2);
        key_down = 1'b1;
        step(1);
        check("fresh_down", mv(), 8'b0100);

        // Hit on HOP tick 5, held throughout death hold
        ticks(4);
        hit = 1'b1; timer_done = 1'b1;
        step(1);
        timer_done = 1'b0;
        check("hit_moves", mv(), 8'd0);
        check("hit_rpos", 8'(reset_position), 8'd1);
        check("hit_lives", 8'(lives), 8'd2);
        check("hit_busy", 8'(busy), 8'd1);
        step(1);
        check("hit_rpos_end", 8'(reset_position), 8'd0);
        step(3);
        ticks(29);
        check("dead_busy_29", 8'(busy), 8'd1);
        check("dead_lives_held", 8'(lives), 8'd2);
        check("dead_rpos", 8'(reset_position), 8'd0);
        hit = 1'b0;
        tick();
        check("dead_busy_30", 8'(busy), 8'd0);
        check("dead_lives_end", 8'(lives), 8'd2);
        key_down = 1'b0;
        step(2);

        // Remaining lives to game over, then restart
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check("hit2_lives", 8'(lives), 8'd1);
        step(4);
        ticks(30);
        check("hit2_idle", 8'(busy), 8'd0);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check("hit3_lives", 8'(lives), 8'd0);
        check("hit3_gover", 8'(game_over), 8'd1);
        key_up = 1'b1;
        step(2);
        check("over_key_up", 8'(up), 8'd0);
        check("over_busy", 8'(busy), 8'd1);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check("over_lives_floor", 8'(lives), 8'd0);
        game_start = 1'b1;
        step(1);
        game_start = 1'b0;
        check("gs_lives", 8'(lives), 8'd3);
        check("gs_gover", 8'(game_over), 8'd0);
        check("gs_rpos", 8'(reset_position), 8'd1);
        check("gs_busy", 8'(busy), 8'd0);
        step(1);
        check("gs_rpos_end", 8'(reset_position), 8'd0);
        key_up = 1'b0;
        step(2);

        // Key held while reset released is not a press
        key_right = 1'b1;
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(3);
        check("rst_held_busy", 8'(busy), 8'd0);
        check("rst_held_right", 8'(right), 8'd0);
        key_right = 1'b0;
        step(2);

        // Lose a life, then async reset mid-hop
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        check("pre_rst_lives", 8'(lives), 8'd2);
        step(4);
        ticks(30);
        key_right = 1'b1;
        step(1);
        check("pre_rst_right", 8'(right), 8'd1);
        ticks(3);
        #2 rstn = 1'b0;
        #1;
        check("async_moves", mv(), 8'd0);
        check("async_lives", 8'(lives), 8'd3);
        check("async_busy", 8'(busy), 8'd0);
        step(1);
        rstn = 1'b1;
        key_right = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
